// File: rtl/imem_loader_if.sv
// Byte-stream input handshake and IMEM write bus for the program loader.
// The slave modport is the loader; master is the stream source / memory side.
interface imem_loader_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;

  modport slave (
    input  in_valid, in_data,
    output in_ready, wr_en, wr_addr, wr_data
  );

  modport master (
    output in_valid, in_data,
    input  in_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/imem_loader.sv
// Framed byte-stream loader: SYNC, 16-bit LE word count, LE data words, XOR checksum.
// Writes words to IMEM from address 0 and holds the core while a load is running.
module imem_loader #(
  parameter int          ADDR_W    = 8,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  imem_loader_if.slave  bus,
  output logic          o_cpu_hold,
  output logic          o_load_done,
  output logic          o_err_len,
  output logic          o_err_csum
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CNT_LO = 3'd1;
  localparam logic [2:0] ST_CNT_HI = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_WRITE  = 3'd4;
  localparam logic [2:0] ST_CHECK  = 3'd5;

  localparam int unsigned MAX_WORDS = 1 << ADDR_W;

  logic [2:0]        r_state;
  logic [15:0]       r_cnt;
  logic [ADDR_W:0]   r_word_cnt;
  logic [1:0]        r_byte_cnt;
  logic [7:0]        r_csum;
  logic [31:0]       r_word;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [31:0]       r_wr_data;
  logic              r_cpu_hold;
  logic              r_load_done;
  logic              r_err_len;
  logic              r_err_csum;

  logic              w_ready;
  logic              w_xfer;
  logic [15:0]       w_n;
  logic [ADDR_W:0]   w_word_inc;
  logic [31:0]       w_word_full;

  assign w_ready     = (r_state != ST_WRITE);
  assign w_xfer      = bus.in_valid && w_ready;
  assign w_n         = {bus.in_data, r_cnt[7:0]};
  assign w_word_inc  = r_word_cnt + 1'b1;
  // The 4th byte is merged combinationally so the whole word is registered at once.
  assign w_word_full = {bus.in_data, r_word[23:0]};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_word_cnt  <= '0;
      r_byte_cnt  <= '0;
      r_csum      <= '0;
      r_word      <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_cpu_hold  <= 1'b0;
      r_load_done <= 1'b0;
      r_err_len   <= 1'b0;
      r_err_csum  <= 1'b0;
    end else begin
      r_load_done <= 1'b0;
      r_wr_en     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_xfer && (bus.in_data == SYNC_BYTE)) begin
            r_state    <= ST_CNT_LO;
            r_cpu_hold <= 1'b1;
            r_err_len  <= 1'b0;
            r_err_csum <= 1'b0;
            r_word_cnt <= '0;
            r_byte_cnt <= '0;
            r_csum     <= '0;
          end
        end
        ST_CNT_LO: begin
          if (w_xfer) begin
            r_cnt[7:0] <= bus.in_data;
            r_state    <= ST_CNT_HI;
          end
        end
        ST_CNT_HI: begin
          if (w_xfer) begin
            r_cnt[15:8] <= bus.in_data;
            if (32'(w_n) > MAX_WORDS) begin
              r_err_len  <= 1'b1;
              r_cpu_hold <= 1'b0;
              r_state    <= ST_IDLE;
            end else if (w_n == 16'd0) begin
              r_state <= ST_CHECK;
            end else begin
              r_state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (w_xfer) begin
            r_csum                   <= r_csum ^ bus.in_data;
            r_word[r_byte_cnt*8 +: 8] <= bus.in_data;
            r_byte_cnt               <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              r_state   <= ST_WRITE;
              r_wr_en   <= 1'b1;
              r_wr_addr <= r_word_cnt[ADDR_W-1:0];
              r_wr_data <= w_word_full;
            end
          end
        end
        ST_WRITE: begin
          r_word_cnt <= w_word_inc;
          r_state    <= (16'(w_word_inc) == r_cnt) ? ST_CHECK : ST_DATA;
        end
        ST_CHECK: begin
          if (w_xfer) begin
            if (bus.in_data == r_csum) begin
              r_load_done <= 1'b1;
            end else begin
              r_err_csum <= 1'b1;
            end
            r_cpu_hold <= 1'b0;
            r_state    <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready = w_ready;
  assign bus.wr_en    = r_wr_en;
  assign bus.wr_addr  = r_wr_addr;
  assign bus.wr_data  = r_wr_data;
  assign o_cpu_hold   = r_cpu_hold;
  assign o_load_done  = r_load_done;
  assign o_err_len    = r_err_len;
  assign o_err_csum   = r_err_csum;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected IMEM writes are queued as words are sent
// and popped by a negedge monitor when wr_en is seen.
module tb_imem_loader;
  localparam logic [7:0] SYNC = 8'hA5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cpu_hold, load_done, err_len, err_csum;

  imem_loader_if #(.ADDR_W(8)) bus ();

  imem_loader #(.ADDR_W(8), .SYNC_BYTE(SYNC)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .bus         (bus),
    .o_cpu_hold  (cpu_hold),
    .o_load_done (load_done),
    .o_err_len   (err_len),
    .o_err_csum  (err_csum)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int hold_cycles = 0;
  bit prev_wr = 1'b0;
  logic [7:0] last_addr = '0;
  logic [39:0] exp_q[$];
  logic [31:0] wq[$];
  logic [7:0] acc;
  logic [7:0] addr_m;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Write monitor / scoreboard consumer
  always @(negedge clk) begin
    logic [39:0] e;
    if (bus.wr_en === 1'b1) begin
      wr_cnt++;
      last_addr = bus.wr_addr;
      if (exp_q.size() == 0) begin
        chk("wr_pending", 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 64'(bus.wr_addr), 64'(e[39:32]));
        chk("wr_data", 64'(bus.wr_data), 64'(e[31:0]));
      end
      chk("hold_at_wr", 64'(cpu_hold), 64'd1);
      chk("wr_not_b2b", 64'(prev_wr), 64'd0);
    end
    if (load_done === 1'b1) begin
      done_cnt++;
      chk("done_no_err", 64'({err_len, err_csum}), 64'd0);
    end
    if (cpu_hold === 1'b1) hold_cycles++;
    prev_wr = (bus.wr_en === 1'b1);
  end

  task automatic send(input logic [7:0] b, input int gaps);
    int guard = 0;
    repeat (gaps) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (bus.in_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) chk("ready_timeout", 64'(guard), 64'd0);
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic send_word(input logic [31:0] w, input bit expect_wr, input int gapmax);
    for (int k = 0; k < 4; k++) begin
      if (k == 3 && expect_wr) exp_q.push_back({addr_m, w});
      acc = acc ^ w[8*k +: 8];
      send(w[8*k +: 8], $urandom_range(0, gapmax));
    end
    addr_m = addr_m + 8'd1;
  endtask

  // Sends SYNC, count, all words in wq, then the checksum (or csum_ovr[7:0] if bit 8 set).
  task automatic run_frame(input int gapmax, input logic [8:0] csum_ovr);
    logic [15:0] n;
    n = 16'(wq.size());
    acc = 8'h00;
    addr_m = 8'h00;
    send(SYNC, 0);
    send(n[7:0], 0);
    send(n[15:8], 0);
    foreach (wq[i]) send_word(wq[i], 1'b1, gapmax);
    send(csum_ovr[8] ? csum_ovr[7:0] : acc, 0);
  endtask

  initial begin
    int base_wr, base_done, g;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_wr_en", 64'(bus.wr_en), 64'd0);
    chk("rst_wr_addr", 64'(bus.wr_addr), 64'd0);
    chk("rst_wr_data", 64'(bus.wr_data), 64'd0);
    chk("rst_flags", 64'({cpu_hold, load_done, err_len, err_csum}), 64'd0);
    rst_n = 1'b1;

    // Two-word program preceded by garbage bytes
    send(8'h00, 0);
    send(8'h13, 0);
    idle(1);
    chk("garbage_no_hold", 64'(cpu_hold), 64'd0);
    wq = {32'h00500093, 32'h00300113};
    base_wr = wr_cnt; base_done = done_cnt;
    run_frame(0, 9'h000);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("t1_done_pulse", 64'(load_done), 64'd1);
    chk("t1_hold_fall", 64'(cpu_hold), 64'd0);
    idle(2);
    chk("t1_writes", 64'(wr_cnt - base_wr), 64'd2);
    chk("t1_done_cnt", 64'(done_cnt - base_done), 64'd1);
    chk("t1_errs", 64'({err_len, err_csum}), 64'd0);

    // Empty frame
    hold_cycles = 0; base_wr = wr_cnt; base_done = done_cnt;
    wq = {};
    run_frame(0, 9'h000);
    idle(3);
    chk("t2_hold_cycles", 64'(hold_cycles), 64'd3);
    chk("t2_no_writes", 64'(wr_cnt - base_wr), 64'd0);
    chk("t2_done_cnt", 64'(done_cnt - base_done), 64'd1);

    // Bad checksum, then a good frame clears the error
    wq = {32'h00500093, 32'h00300113};
    base_wr = wr_cnt; base_done = done_cnt;
    run_frame(0, 9'h1FF);
    idle(2);
    chk("t3_err_csum", 64'(err_csum), 64'd1);
    chk("t3_writes", 64'(wr_cnt - base_wr), 64'd2);
    chk("t3_no_done", 64'(done_cnt - base_done), 64'd0);
    wq = {32'hDEADBEEF};
    run_frame(1, 9'h000);
    idle(2);
    chk("t3_err_cleared", 64'(err_csum), 64'd0);
    chk("t3_done_after", 64'(done_cnt - base_done), 64'd1);

    // Oversized count (257)
    base_wr = wr_cnt;
    send(SYNC, 0); send(8'h01, 0); send(8'h01, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("t4_err_len", 64'(err_len), 64'd1);
    chk("t4_hold", 64'(cpu_hold), 64'd0);
    send(SYNC, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("t4_err_len_clr", 64'(err_len), 64'd0);
    send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
    idle(2);
    chk("t4_no_writes", 64'(wr_cnt - base_wr), 64'd0);

    // Full 256-word image
    wq = {};
    for (int i = 0; i < 256; i++) wq.push_back(32'hC0DE0000 | 32'(i));
    base_wr = wr_cnt; base_done = done_cnt;
    run_frame(0, 9'h000);
    idle(2);
    chk("t5_writes", 64'(wr_cnt - base_wr), 64'd256);
    chk("t5_last_addr", 64'(last_addr), 64'hFF);
    chk("t5_done", 64'(done_cnt - base_done), 64'd1);

    // Gappy 3-word load with reset after word 1
    base_wr = wr_cnt; base_done = done_cnt;
    acc = 8'h00; addr_m = 8'h00;
    send(SYNC, 0); send(8'h03, 1); send(8'h00, 2);
    send_word(32'h00A00513, 1'b1, 3);
    idle(1);
    g = 0;
    while (wr_cnt < base_wr + 1 && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("t6_word1", 64'(wr_cnt - base_wr), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_outs", 64'({bus.in_ready, bus.wr_en, cpu_hold, load_done, err_len, err_csum}), 64'b100000);
    chk("t6_rst_addr", 64'(bus.wr_addr), 64'd0);
    chk("t6_rst_data", 64'(bus.wr_data), 64'd0);
    chk("t6_q_empty", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send_word(32'h11223344, 1'b0, 2);
    send_word(32'h55667788, 1'b0, 2);
    send(8'h3C, 1);
    idle(3);
    chk("t6_ignored_wr", 64'(wr_cnt - base_wr), 64'd1);
    chk("t6_ignored_hold", 64'(cpu_hold), 64'd0);
    wq = {32'h00A00513, 32'h11223344, 32'h55667788};
    run_frame(3, 9'h000);
    idle(2);
    chk("t6_reload_wr", 64'(wr_cnt - base_wr), 64'd4);
    chk("t6_reload_done", 64'(done_cnt - base_done), 64'd1);
    chk("t6_q_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL global_timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end
endmodule
